alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_adder.sv | 30 +++
 rtl/alu_iter.sv | 147 ++++++++++++++
 tb/tb_alu_iter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: operation codes used by the
// ALU control stage and the sequencing FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_AND  = 4'b0001;
    localparam logic [3:0] ALU_OP_OR   = 4'b0010;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0011;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0100;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0101;
    localparam logic [3:0] ALU_OP_SLTU = 4'b0110;
    localparam logic [3:0] ALU_OP_SLL  = 4'b1000;
    localparam logic [3:0] ALU_OP_SRL  = 4'b1001;
    localparam logic [3:0] ALU_OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // Low two opcode bits of the shift group select the shift flavour.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_kind_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
    endfunction

endpackage

// File: rtl/alu_adder.sv
// Adder path of the ALU: a + (invert ? ~b : b) + carry-in, with carry-out
// and two's-complement overflow.
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             invert_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    // Conditionally inverted B operand and full-width sum including carry-out.
    always_comb begin
        b_eff = invert_i ? ~b_i : b_i;
        full  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_i};
    end

    assign sum_o  = full[WIDTH-1:0];
    assign cout_o = full[WIDTH];
    // Overflow: both addends share a sign that differs from the sum's sign.
    assign ovf_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (full[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu_iter.sv
// Iterative-shift ALU. Logic/arithmetic ops complete in one cycle; shifts
// move one bit per clock unless ALU_BARREL_SHIFT_EN is defined, in which
// case shifts are combinational and also complete in one cycle.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       aluop_i,
    input  logic             c_i,
    input  logic             invert_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] imm_res;
    logic             start_shift;
    logic [WIDTH-1:0] step_d;

    alu_state_e       state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             done_q;
    logic             busy_q;
    logic [WIDTH-1:0] op_q;
    logic [SHW-1:0]   cnt_q;
    shift_kind_e      kind_q;

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a_i      (a_i),
        .b_i      (b_i),
        .invert_i (invert_i),
        .c_i      (c_i),
        .sum_o    (sum),
        .cout_o   (cout),
        .ovf_o    (ovf)
    );

    assign shamt = b_i[SHW-1:0];

`ifdef ALU_BARREL_SHIFT_EN
    assign start_shift = 1'b0;
`else
    assign start_shift = is_shift_op(aluop_i) && (shamt != '0);
`endif

    // Single-cycle result for the current inputs (shifts by 0 pass A through
    // in iterative mode; with the barrel option every shift resolves here).
    always_comb begin
        imm_res = sum;
        case (aluop_i)
            ALU_OP_AND:  imm_res = a_i & b_i;
            ALU_OP_OR:   imm_res = a_i | b_i;
            ALU_OP_XOR:  imm_res = a_i ^ b_i;
            ALU_OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            ALU_OP_SLTU: imm_res = {{(WIDTH-1){1'b0}}, ~cout};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_OP_SLL:  imm_res = a_i << shamt;
            ALU_OP_SRL:  imm_res = a_i >> shamt;
            ALU_OP_SRA:  imm_res = $signed(a_i) >>> shamt;
`else
            ALU_OP_SLL,
            ALU_OP_SRL,
            ALU_OP_SRA:  imm_res = a_i;
`endif
            default:     imm_res = sum;
        endcase
    end

    // One-bit shift of the latched operand.
    always_comb begin
        case (kind_q)
            SH_SLL:  step_d = {op_q[WIDTH-2:0], 1'b0};
            SH_SRL:  step_d = {1'b0, op_q[WIDTH-1:1]};
            default: step_d = {op_q[WIDTH-1], op_q[WIDTH-1:1]};
        endcase
    end

    // Sequencing FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            op_q     <= '0;
            cnt_q    <= '0;
            kind_q   <= SH_SLL;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        if (start_shift) begin
                            op_q    <= a_i;
                            cnt_q   <= shamt;
                            kind_q  <= shift_kind_e'(aluop_i[1:0]);
                            busy_q  <= 1'b1;
                            state_q <= ST_SHIFT;
                        end else begin
                            result_q <= imm_res;
                            zero_q   <= (imm_res == '0);
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    op_q  <= step_d;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        result_q <= step_d;
                        zero_q   <= (step_d == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: stimulus pushes expected result/zero/done
// cycle, a negedge monitor pops and compares on every done_o pulse.
module tb_alu_iter;
    import alu_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [3:0]  aluop_i = '0;
    logic        c_i = 1'b0;
    logic        invert_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;

    alu_iter #(.WIDTH(32), .SHW(5)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .aluop_i  (aluop_i),
        .c_i      (c_i),
        .invert_i (invert_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned busy_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy_o) busy_cnt <= busy_cnt + 1;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clk) begin
        if (rst_ni && done_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 required 0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, result_o, e.res);
                check({e.name, "_zero"}, {31'b0, zero_o}, {31'b0, e.z});
                check({e.name, "_done_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one request at the current negedge; lat = cycles until done_o.
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic c, input logic inv,
                         input logic [31:0] exp_res, input int unsigned lat, input bit push);
        exp_t x;
        start_i  = 1'b1;
        aluop_i  = op;
        a_i      = a;
        b_i      = b;
        c_i      = c;
        invert_i = inv;
        if (push) begin
            x.res  = exp_res;
            x.z    = (exp_res == 32'h0);
            x.cyc  = cyc + lat;
            x.name = name;
            sb.push_back(x);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done_timeout: got %0d outstanding required 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    task automatic run1(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic c, input logic inv,
                        input logic [31:0] exp_res, input int unsigned lat);
        tick();
        issue(name, op, a, b, c, inv, exp_res, lat, 1'b1);
        tick();
        start_i = 1'b0;
        wait_idle();
    endtask

    initial begin
        int unsigned bc0;
        int unsigned sh_lat4;
        int unsigned sh_lat31;
        sh_lat4  = BARREL ? 1 : 5;
        sh_lat31 = BARREL ? 1 : 32;

        repeat (3) tick();
        check("rst_result", result_o, 32'h0);
        check("rst_zero", {31'b0, zero_o}, 32'h1);
        check("rst_busy", {31'b0, busy_o}, 32'h0);
        check("rst_done", {31'b0, done_o}, 32'h0);

        // First request presented together with reset release.
        tick();
        rst_ni = 1'b1;
        issue("add_first", ALU_OP_ADD, 32'd5, 32'd3, 1'b0, 1'b0, 32'd8, 1, 1'b1);
        tick();
        start_i = 1'b0;
        wait_idle();

        run1("sub_zero", ALU_OP_SUB,  32'd3,        32'd3, 1'b1, 1'b1, 32'h0, 1);
        run1("slt_neg",  ALU_OP_SLT,  32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 32'h1, 1);
        run1("sltu",     ALU_OP_SLTU, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 32'h0, 1);
        run1("slt_ovf",  ALU_OP_SLT,  32'h80000000, 32'd1, 1'b1, 1'b1, 32'h1, 1);
        run1("and",      ALU_OP_AND,  32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0, 32'h0000F000, 1);
        run1("or",       ALU_OP_OR,   32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0, 32'h0000FFF0, 1);
        run1("xor",      ALU_OP_XOR,  32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0, 32'h00000FF0, 1);
        run1("undef7",   4'b0111,     32'd5, 32'd3, 1'b0, 1'b0, 32'd8, 1);
        run1("undefF",   4'b1111,     32'd5, 32'd3, 1'b0, 1'b0, 32'd8, 1);
        run1("srl4",     ALU_OP_SRL,  32'h000000F0, 32'd4, 1'b0, 1'b0, 32'h0000000F, sh_lat4);

        // sra with a start pulse during the shift that must be ignored.
        bc0 = busy_cnt;
        tick();
        issue("sra4", ALU_OP_SRA, 32'h80000000, 32'd4, 1'b0, 1'b0, 32'hF8000000, sh_lat4, 1'b1);
        tick();
        start_i = 1'b0;
        if (!BARREL) begin
            tick();
            issue("ignored", ALU_OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1, 1'b0);
            tick();
            start_i = 1'b0;
        end
        wait_idle();
        check("sra4_busy_cycles", busy_cnt - bc0, BARREL ? 32'd0 : 32'd4);

        bc0 = busy_cnt;
        run1("sll31", ALU_OP_SLL, 32'h1, 32'd31, 1'b0, 1'b0, 32'h80000000, sh_lat31);
        check("sll31_busy_cycles", busy_cnt - bc0, BARREL ? 32'd0 : 32'd31);
        run1("sll0", ALU_OP_SLL, 32'h1, 32'd0, 1'b0, 1'b0, 32'h1, 1);

        // Reset in the middle of a 10-step srl: discarded, outputs at reset values.
        tick();
        issue("srl10", ALU_OP_SRL, 32'hFFFF0000, 32'd10, 1'b0, 1'b0, 32'h003FFFC0, 1, BARREL);
        tick();
        start_i = 1'b0;
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_result", result_o, 32'h0);
        check("midrst_zero", {31'b0, zero_o}, 32'h1);
        check("midrst_busy", {31'b0, busy_o}, 32'h0);
        check("midrst_done", {31'b0, done_o}, 32'h0);
        sb.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        repeat (12) tick();
        run1("add_after_rst", ALU_OP_ADD, 32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 1);

        // Back-to-back issue with start held high.
        tick();
        issue("b2b0", ALU_OP_ADD, 32'd1,  32'd1,  1'b0, 1'b0, 32'd2,  1, 1'b1);
        tick();
        issue("b2b1", ALU_OP_ADD, 32'd2,  32'd3,  1'b0, 1'b0, 32'd5,  1, 1'b1);
        tick();
        issue("b2b2", ALU_OP_ADD, 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1, 1'b1);
        tick();
        issue("b2b3", ALU_OP_ADD, 32'd0,  32'd0,  1'b0, 1'b0, 32'd0,  1, 1'b1);
        tick();
        start_i = 1'b0;
        wait_idle();
        check("final_busy", {31'b0, busy_o}, 32'h0);

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
